mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port unified instruction/data memory between the pipeline's instruction-fetch stage and its memory stage. The memory has a combinational read and a clocked write. Each cycle the arbiter grants at most one requester and drives that requester's address, write data and write enable onto the memory. Read data is returned one cycle later through a registered response. Data accesses win by default, and a starvation limit guarantees forward progress for fetch.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares a single-port unified instruction/data memory between the fetch
// stage and the memory stage of the pipeline. At most one requester is
// granted per cycle, and the granted requester's address, write data and
// write enable are driven onto the memory. Read data comes back one cycle
// later through a registered response. Data accesses normally win.
// Fetch gains priority after STARVE_LIMIT consecutive denied cycles.
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   if_req/if_addr                  fetch read request (held until if_gnt)
//   if_gnt                          combinational fetch grant
//   if_rvalid/if_rdata              registered fetch response (1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata       data-port request (held until d_gnt)
//   d_gnt                           combinational data grant
//   d_rvalid/d_rdata                registered data response; for a store
//                                   this is the word before the write
//   mem_we/mem_a/mem_wd/mem_rd      memory port (combinational read)
//   conflict_cnt                    cycles with both requests high (wraps)
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [31:0] conflict_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    logic [31:0] conflict_q;
    logic        fetch_pri;

    assign conflict_cnt = conflict_q;

    // Grants include reset_n so the memory is idle during reset without
    // waiting for a clock edge.
    always_comb begin
        fetch_pri = (starve_cnt == LIMIT);
        d_gnt     = reset_n & d_req & (~if_req | ~fetch_pri);
        if_gnt    = reset_n & if_req & ~d_gnt;
        mem_we    = 1'b0;
        mem_a     = 32'd0;
        mem_wd    = 32'd0;
        if (d_gnt) begin
            mem_we = d_we;
            mem_a  = d_addr;
            mem_wd = d_wdata;
        end else if (if_gnt) begin
            mem_a = if_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= 32'd0;
            d_rdata    <= 32'd0;
            starve_cnt <= 4'd0;
            conflict_q <= 32'd0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt;
            if (if_gnt) begin
                if_rdata <= mem_rd;
            end
            // mem_rd is sampled before the store lands, so a store
            // returns the old word.
            if (d_gnt) begin
                d_rdata <= mem_rd;
            end

            // Counts consecutive cycles where fetch asked and lost to data.
            if (!if_req || if_gnt) begin
                starve_cnt <= 4'd0;
            end else if (d_gnt && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (if_req && d_req) begin
                conflict_q <= conflict_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase. The driver predicts each cycle's grant and pushes the
// expected response word. A separate monitor pops the expected word and
// compares it when the response is presented.
module tb_mem_arbiter;

    localparam int LIMIT = 3;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] conflict_cnt;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        if (i == 16) return 32'h1111_1111;
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Memory attached to the DUT: 64 words, combinational read, clocked write.
    logic [31:0] ram [64];
    bit          ram_loaded;
    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_a[7:2]] <= mem_wd;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    logic [31:0] if_q [$];
    logic [31:0] d_q [$];
    logic [31:0] last_if, last_d;
    logic [31:0] conf_model;
    int          pend_inc;
    int          if_wait;
    bit          if_pend, d_pend;
    string       seq;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic model_reset();
        if_q.delete();
        d_q.delete();
        last_if    = 32'd0;
        last_d     = 32'd0;
        conf_model = 32'd0;
        pend_inc   = 0;
        if_wait    = 0;
        if_pend    = 1'b0;
        d_pend     = 1'b0;
    endtask

    // One request cycle: drive inputs after the falling edge, then predict
    // and check the combinational grant and the memory bus.
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        logic        exp_d, exp_f, exp_we;
        logic [31:0] exp_a, exp_wd;
        @(negedge clk);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        #1;
        exp_d  = reset_n && dr && !(ir && (if_wait == LIMIT));
        exp_f  = reset_n && ir && !exp_d;
        exp_we = exp_d ? dwe : 1'b0;
        exp_a  = exp_d ? da : (exp_f ? ia : 32'd0);
        exp_wd = exp_d ? dwd : 32'd0;
        chk("d_gnt", 32'(d_gnt), 32'(exp_d));
        chk("if_gnt", 32'(if_gnt), 32'(exp_f));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_a", mem_a, exp_a);
        chk("mem_wd", mem_wd, exp_wd);
        if (d_gnt) seq = {seq, "D"};
        else if (if_gnt) seq = {seq, "F"};
        else seq = {seq, "-"};
        if (exp_d) begin
            d_q.push_back(ref_mem[da[7:2]]);
            if (dwe) ref_mem[da[7:2]] = dwd;
        end
        if (exp_f) if_q.push_back(ref_mem[ia[7:2]]);
        if (reset_n) begin
            if (ir && dr) pend_inc++;
            if (ir && exp_d) if_wait = (if_wait == LIMIT) ? LIMIT : if_wait + 1;
            else if_wait = 0;
        end
        if_pend = ir && !exp_f;
        d_pend  = dr && !exp_d;
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Monitor: samples just after each rising edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #2;
            conf_model = conf_model + 32'(pend_inc);
            pend_inc = 0;
            chk("conflict_cnt", conflict_cnt, conf_model);
            if (if_q.size() > 0) begin
                e = if_q.pop_front();
                chk("if_rvalid", 32'(if_rvalid), 32'd1);
                chk("if_rdata", if_rdata, e);
                last_if = e;
            end else begin
                chk("if_rvalid_idle", 32'(if_rvalid), 32'd0);
                chk("if_rdata_hold", if_rdata, last_if);
            end
            if (d_q.size() > 0) begin
                e = d_q.pop_front();
                chk("d_rvalid", 32'(d_rvalid), 32'd1);
                chk("d_rdata", d_rdata, e);
                last_d = e;
            end else begin
                chk("d_rvalid_idle", 32'(d_rvalid), 32'd0);
                chk("d_rdata_hold", d_rdata, last_d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        r_ir, r_dr, r_dwe;
    logic [31:0] r_ia, r_da, r_dwd;

    initial begin
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        model_reset();
        seq = "";
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #3 reset_n = 1'b1;

        // Fetch-only stream
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 32'd0, 32'd0);
        idle();
        chk("fetch_stream_conflicts", conflict_cnt, 32'd0);

        // Store then load at 0x40
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        chk("store_old_word", d_rdata, 32'h1111_1111);
        idle();
        chk("load_new_word", d_rdata, 32'hDEAD_BEEF);

        // Continuous conflict
        seq = "";
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'(i * 4 + 32'h80), 32'd0);
        chk_s("conflict_pattern", seq, "DDDFDDDF");
        idle();
        chk("conflict_cnt_8", conflict_cnt, 32'd8);

        // Dropping fetch request clears starvation
        seq = "";
        cycle(1'b1, 32'h24, 1'b1, 1'b0, 32'h84, 32'd0);
        cycle(1'b1, 32'h24, 1'b1, 1'b0, 32'h88, 32'd0);
        cycle(1'b0, 32'h24, 1'b1, 1'b0, 32'h8C, 32'd0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h24, 1'b1, 1'b0, 32'(i * 4 + 32'h90), 32'd0);
        chk_s("starve_restart_pattern", seq, "DDDDDDF");
        idle();

        // Reset mid-stream while a data response is pending
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h44, 32'h1234_5678);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h44, 32'd0);
        d_we = 1'b1;
        if_req = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_conflict_cnt", conflict_cnt, 32'd0);
        model_reset();
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h48, 32'hFFFF_0000);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'd0);
        reset_n = 1'b1;
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("first_fetch_gnt", 32'(if_gnt), 32'd1);
        idle();
        chk("first_fetch_data", if_rdata, init_val(0));

        // Counter wrap via backdoor preload
        force dut.conflict_q = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_q;
        conf_model = 32'hFFFF_FFFE;
        cycle(1'b1, 32'h30, 1'b1, 1'b0, 32'h50, 32'd0);
        cycle(1'b1, 32'h30, 1'b1, 1'b0, 32'h54, 32'd0);
        idle();
        chk("conflict_wrap", conflict_cnt, 32'd0);
        idle();

        // Randomized traffic
        r_ir = 1'b0; r_ia = 32'd0;
        r_dr = 1'b0; r_dwe = 1'b0; r_da = 32'd0; r_dwd = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!if_pend) begin
                r_ir = ($urandom_range(0, 2) != 0);
                r_ia = $urandom;
            end
            if (!d_pend) begin
                r_dr  = ($urandom_range(0, 2) != 0);
                r_dwe = 1'($urandom_range(0, 1));
                r_da  = $urandom;
                r_dwd = $urandom;
            end
            cycle(r_ir, r_ia, r_dr, r_dwe, r_da, r_dwd);
        end
        idle();
        idle();
        idle();
        chk("if_queue_drained", 32'(if_q.size()), 32'd0);
        chk("d_queue_drained", 32'(d_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
